rpm_datapath: RTL

Datapath for the Russian-peasant (shift-and-add) multiplier. It is driven by the multiplier controller's select, load and enable strobes, and returns the two status flags that steer that controller.
It holds the halving multiplier register X, the doubling multiplicand register Y, the accumulator, and the registered product with a done pulse.
It sits directly downstream of the controller and upstream of the result consumer.

---
 rtl/rpm_datapath.sv | 104 ++++++++++
 1 files changed

// File: rtl/rpm_datapath.sv
`default_nettype none
// ============================================================================
// Module      : rpm_datapath
// Description : Shift-and-add (Russian-peasant) multiplier datapath. Holds the
//               halving X register, doubling Y register, accumulator and the
//               registered product with a done pulse. Optional macro
//               RPM_DP_STATS_EN enables the iter_count shift counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rpm_datapath #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic           x_sel,
    input  logic           y_sel,
    input  logic           x_ld,
    input  logic           y_ld,
    input  logic           add_en,
    input  logic           out_en,
    output logic           x_flag,
    output logic           x_odd_flag,
    output logic [2*W-1:0] product,
    output logic           done,
    output logic [7:0]     iter_count
);

    logic [W-1:0]   r_x;
    logic [2*W-1:0] r_y;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_product;
    logic           r_done;

    logic           w_op_load;
    logic           w_x_shift;

    assign w_op_load  = x_ld && !x_sel;
    assign w_x_shift  = x_ld && x_sel;

    // Status flags come from the X register only, never from the inputs.
    assign x_flag     = (r_x == '0) || (r_x == W'(1));
    assign x_odd_flag = r_x[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_op_load) begin
                r_x <= a_in;
            end else if (w_x_shift) begin
                r_x <= r_x >> 1;
            end

            if (y_ld && !y_sel) begin
                r_y <= {{W{1'b0}}, b_in};
            end else if (y_ld && y_sel) begin
                r_y <= r_y << 1;
            end

            // Operand load clears the accumulator ahead of any add in the same cycle.
            if (w_op_load) begin
                r_acc <= '0;
            end else if (add_en && r_x[0]) begin
                r_acc <= r_acc + r_y;
            end

            if (out_en) begin
                r_product <= r_acc;
                r_done    <= 1'b1;
            end else begin
                r_done    <= 1'b0;
            end
        end
    end

    assign product = r_product;
    assign done    = r_done;

`ifdef RPM_DP_STATS_EN
    logic [7:0] r_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter <= 8'd0;
        end else if (w_op_load) begin
            r_iter <= 8'd0;
        end else if (w_x_shift && (r_iter != 8'hFF)) begin
            r_iter <= r_iter + 8'd1;
        end
    end

    assign iter_count = r_iter;
`else
    assign iter_count = 8'd0;
`endif

endmodule
`default_nettype wire
